pq_cmd_issuer: RTL and testbench

- Initiator-side sequencer for the register-tree priority queue (max at root).
- Accepts ENQUEUE / DEQUEUE / REPLACE / PEEK commands over a valid/ready channel and drives the queue's write, read and data strobes.
- Waits a fixed settle interval for the tree to re-order, then returns the result over a valid/ready response channel.
- Replaces hand-timed stimulus, so upstream schedulers can use the queue without knowing its settle latency or full/empty rules.

---
 rtl/pq_cmd_pkg.sv | 35 +++
 rtl/pq_cmd_issuer.sv | 195 +++++++++++++++++++
 tb/tb_pq_cmd_issuer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pq_cmd_pkg.sv
// ---------------------------------------------------------------------------
// pq_cmd_pkg
// Shared types for the register-tree priority queue and its command issuer.
//   pq_op_t            command opcodes (also used by the queue benches)
//   pq_status_t        response status codes
//   pq_issuer_state_t  issuer FSM state encoding
//   sat_inc16          saturating 16-bit increment for the statistics counters
// ---------------------------------------------------------------------------
package pq_cmd_pkg;

  typedef enum logic [1:0] {
    ENQUEUE = 2'b00,
    DEQUEUE = 2'b01,
    REPLACE = 2'b10,
    PEEK    = 2'b11
  } pq_op_t;

  typedef enum logic [1:0] {
    OK        = 2'b00,
    REJ_FULL  = 2'b01,
    REJ_EMPTY = 2'b10
  } pq_status_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_SETTLE = 2'b10,
    ST_RESP   = 2'b11
  } pq_issuer_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pq_cmd_issuer.sv
// ---------------------------------------------------------------------------
// pq_cmd_issuer
// Initiator-side sequencer for the register-tree priority queue (max at root).
// Takes one command at a time, strobes the queue, waits out the tree settle
// time, and returns the result on a valid/ready response channel.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cmd_ready high, waiting for a command
// ISSUE  | one cycle with pq_wrt / pq_read driven for the accepted op
// SETTLE | strobes low, counting down while the tree re-orders
// RESP   | response held on rsp_* until rsp_ready
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   cmd_valid/ready/op/data  command channel
//   rsp_valid/ready/data/status  response channel
//   pq_wrt, pq_read, pq_data strobes and data to the queue
//   pq_full, pq_empty, pq_top  queue status and current root
//   stat_issued, stat_rejected  only with PQ_CMD_ISSUER_STATS_EN defined
//
// Build option: define PQ_CMD_ISSUER_STATS_EN to add saturating counters of
// issued commands and rejected responses.
// ---------------------------------------------------------------------------
module pq_cmd_issuer
  import pq_cmd_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic                  pq_wrt,
  output logic                  pq_read,
  output logic [DATA_WIDTH-1:0] pq_data,
  input  logic                  pq_full,
  input  logic                  pq_empty,
  input  logic [DATA_WIDTH-1:0] pq_top
`ifdef PQ_CMD_ISSUER_STATS_EN
  ,
  output logic [15:0]           stat_issued,
  output logic [15:0]           stat_rejected
`endif
);

  localparam int CNT_WIDTH = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] ISSUE  = ST_ISSUE;
  localparam logic [1:0] SETTLE = ST_SETTLE;
  localparam logic [1:0] RESP   = ST_RESP;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_removed;
  logic                  r_cmd_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_status;
  logic                  r_pq_wrt;
  logic                  r_pq_read;
  logic [DATA_WIDTH-1:0] r_pq_data;

  logic w_accept;
  logic w_is_enq;
  logic w_removes;
  logic w_is_peek;
  logic w_rej_full;
  logic w_rej_empty;

  assign w_accept    = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  assign w_is_enq    = (cmd_op == ENQUEUE);
  assign w_removes   = (cmd_op == DEQUEUE) || (cmd_op == REPLACE);
  assign w_is_peek   = (cmd_op == PEEK);
  assign w_rej_full  = w_is_enq && pq_full;
  assign w_rej_empty = w_removes && pq_empty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_op         <= '0;
      r_removed    <= '0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_pq_wrt     <= 1'b0;
      r_pq_read    <= 1'b0;
      r_pq_data    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cmd_ready <= 1'b1;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            if (w_rej_full) begin
              r_state      <= RESP;
              r_rsp_data   <= cmd_data;
              r_rsp_status <= REJ_FULL;
            end else if (w_rej_empty) begin
              r_state      <= RESP;
              r_rsp_data   <= '0;
              r_rsp_status <= REJ_EMPTY;
            end else if (w_is_peek) begin
              r_state      <= RESP;
              r_rsp_data   <= pq_top;
              r_rsp_status <= pq_empty ? REJ_EMPTY : OK;
            end else begin
              r_state   <= ISSUE;
              r_pq_wrt  <= w_is_enq || (cmd_op == REPLACE);
              r_pq_read <= w_removes;
              r_pq_data <= cmd_data;
              r_removed <= pq_top;
            end
          end
        end
        ISSUE: begin
          r_pq_wrt  <= 1'b0;
          r_pq_read <= 1'b0;
          r_cnt     <= CNT_WIDTH'(SETTLE_CYCLES);
          r_state   <= SETTLE;
        end
        SETTLE: begin
          if (r_cnt == CNT_WIDTH'(1)) begin
            r_cnt        <= '0;
            r_state      <= RESP;
            r_rsp_valid  <= 1'b1;
            r_rsp_status <= OK;
            r_rsp_data   <= (r_op == ENQUEUE) ? pq_top : r_removed;
          end else begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
          end
        end
        RESP: begin
          // Rejects and PEEK enter RESP on the acceptance edge with the
          // result already latched; they present it one edge later so the
          // response appears at E1. Settled ops arrive with rsp_valid set.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_status = r_rsp_status;
  assign pq_wrt     = r_pq_wrt;
  assign pq_read    = r_pq_read;
  assign pq_data    = r_pq_data;

`ifdef PQ_CMD_ISSUER_STATS_EN
  logic [15:0] r_stat_issued;
  logic [15:0] r_stat_rejected;
  logic        w_reject;

  // A PEEK on an empty queue is reported as REJ_EMPTY and counts as a reject.
  assign w_reject = w_accept && (w_rej_full || w_rej_empty || (w_is_peek && pq_empty));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_stat_issued   <= '0;
      r_stat_rejected <= '0;
    end else begin
      if (r_state == ISSUE) begin
        r_stat_issued <= sat_inc16(r_stat_issued);
      end
      if (w_reject) begin
        r_stat_rejected <= sat_inc16(r_stat_rejected);
      end
    end
  end

  assign stat_issued   = r_stat_issued;
  assign stat_rejected = r_stat_rejected;
`endif

endmodule

// File: tb/tb_pq_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_pq_cmd_issuer
// Directed bench for pq_cmd_issuer with SETTLE_CYCLES=5. The queue itself is
// not modelled: pq_top / pq_full / pq_empty are driven by hand to mimic the
// tree contents around each command. Outputs are sampled 1 time unit after
// the rising edge; inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_pq_cmd_issuer;
  import pq_cmd_pkg::*;

  localparam int DW = 16;
  localparam int S  = 5;

  logic          CLK;
  logic          RST;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic          pq_wrt;
  logic          pq_read;
  logic [DW-1:0] pq_data;
  logic          pq_full;
  logic          pq_empty;
  logic [DW-1:0] pq_top;
`ifdef PQ_CMD_ISSUER_STATS_EN
  logic [15:0]   stat_issued;
  logic [15:0]   stat_rejected;
`endif

  int total = 0;
  int bad   = 0;

  pq_cmd_issuer #(.DATA_WIDTH(DW), .SETTLE_CYCLES(S)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .pq_wrt     (pq_wrt),
    .pq_read    (pq_read),
    .pq_data    (pq_data),
    .pq_full    (pq_full),
    .pq_empty   (pq_empty),
    .pq_top     (pq_top)
`ifdef PQ_CMD_ISSUER_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_rejected (stat_rejected)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {cmd_ready, rsp_valid, rsp_data, rsp_status, pq_wrt, pq_read, pq_data};
  endfunction

  task automatic check_all_zero(input string tag);
    total++;
    assert (all_outs() === 64'd0) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=0", tag, all_outs());
    end
  endtask

  // Waits (bounded) for cmd_ready, then presents one command across one edge (E0).
  task automatic accept(input logic [1:0] op, input logic [DW-1:0] data, input string tag);
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    chk({tag, "_rdy"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_data  = 16'hDEAD;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
    chk({tag, "_bubble"}, cmd_ready, 0);
    tick();
    chk({tag, "_ready_back"}, cmd_ready, 1);
  endtask

  task automatic issued(input logic [1:0] op, input logic [DW-1:0] data,
                        input logic [DW-1:0] top_after, input logic empty_after,
                        input logic exp_wrt, input logic exp_read,
                        input logic [DW-1:0] exp_rsp, input string tag);
    accept(op, data, tag);
    chk({tag, "_strobe_e0"}, {pq_wrt, pq_read}, {exp_wrt, exp_read});
    chk({tag, "_pq_data_e0"}, pq_data, data);
    chk({tag, "_busy"}, cmd_ready, 0);
    pq_top   = top_after;
    pq_empty = empty_after;
    tick();
    chk({tag, "_strobe_e1"}, {pq_wrt, pq_read}, 0);
    chk({tag, "_pq_data_e1"}, pq_data, data);
    for (int k = 2; k <= S; k++) begin
      tick();
      chk({tag, "_settle"}, {rsp_valid, pq_wrt, pq_read, cmd_ready}, 0);
    end
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
    chk({tag, "_rsp_status"}, rsp_status, OK);
    finish_rsp(tag);
  endtask

  task automatic immediate(input logic [1:0] op, input logic [DW-1:0] data,
                           input logic [1:0] exp_status, input logic [DW-1:0] exp_rsp,
                           input int stall, input string tag);
    accept(op, data, tag);
    chk({tag, "_e0"}, {rsp_valid, pq_wrt, pq_read, cmd_ready}, 0);
    tick();
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_status"}, rsp_status, exp_status);
    chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
    chk({tag, "_no_strobe"}, {pq_wrt, pq_read}, 0);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk({tag, "_stall_hs"}, {rsp_valid, cmd_ready}, 2'b10);
      chk({tag, "_stall_data"}, rsp_data, exp_rsp);
    end
    finish_rsp(tag);
  endtask

  initial begin
    RST       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    rsp_ready = 1'b0;
    pq_full   = 1'b0;
    pq_empty  = 1'b1;
    pq_top    = '0;

    // Reset state
    #2 RST = 1'b1;
    tick();
    tick();
    check_all_zero("reset_outs");
    RST = 1'b0;
    chk("ready_before_edge", cmd_ready, 0);
    tick();
    chk("ready_after_reset", cmd_ready, 1);

    // Enqueue 300, 700, 50, then DEQUEUE and PEEK
    issued(ENQUEUE, 16'd300, 16'd300, 1'b0, 1'b1, 1'b0, 16'd300, "enq300");
    issued(ENQUEUE, 16'd700, 16'd700, 1'b0, 1'b1, 1'b0, 16'd700, "enq700");
    issued(ENQUEUE, 16'd50,  16'd700, 1'b0, 1'b1, 1'b0, 16'd700, "enq50");
    issued(DEQUEUE, 16'd0,   16'd300, 1'b0, 1'b0, 1'b1, 16'd700, "deq");
    immediate(PEEK, 16'd0, OK, 16'd300, 0, "peek1");

    // Queue holds {700,300}: REPLACE 10
    pq_top = 16'd700;
    issued(REPLACE, 16'd10, 16'd300, 1'b0, 1'b1, 1'b1, 16'd700, "repl");
    immediate(PEEK, 16'd0, OK, 16'd300, 0, "peek2");

    // Empty queue rejects; stale pq_top must not leak into DEQUEUE response
    pq_empty = 1'b1;
    pq_top   = 16'h1234;
    immediate(DEQUEUE, 16'd0, REJ_EMPTY, 16'd0, 0, "deq_empty");
    immediate(REPLACE, 16'd8, REJ_EMPTY, 16'd0, 0, "repl_empty");
    immediate(PEEK, 16'd0, REJ_EMPTY, 16'h1234, 0, "peek_empty");

    // Full queue ENQUEUE, response stalled 10 cycles
    pq_full  = 1'b1;
    pq_empty = 1'b0;
    pq_top   = 16'd700;
    immediate(ENQUEUE, 16'd5, REJ_FULL, 16'd5, 10, "enq_full");
    pq_full = 1'b0;

    // Reset during SETTLE of a DEQUEUE
    pq_top = 16'd900;
    accept(DEQUEUE, 16'd0, "rst_settle");
    chk("rst_settle_read", pq_read, 1);
    pq_top = 16'd300;
    tick();
    tick();
    RST = 1'b1;
    #1;
    check_all_zero("rst_settle_outs");
    tick();
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_settle_no_replay", {rsp_valid, pq_wrt, pq_read}, 0);
    end
    chk("rst_settle_ready", cmd_ready, 1);

    // Reset while the write strobe is high
    accept(ENQUEUE, 16'd77, "rst_issue");
    chk("rst_issue_wrt", pq_wrt, 1);
    RST = 1'b1;
    #1;
    check_all_zero("rst_issue_outs");
    tick();
    RST = 1'b0;
    tick();
    chk("rst_issue_ready", cmd_ready, 1);
    chk("rst_issue_no_rsp", {rsp_valid, pq_wrt}, 0);

    // 3 issued + 2 rejected (+ one OK PEEK that counts as neither)
    pq_empty = 1'b1;
    pq_top   = 16'd0;
    issued(ENQUEUE, 16'd1, 16'd1, 1'b0, 1'b1, 1'b0, 16'd1, "s_enq1");
    issued(ENQUEUE, 16'd2, 16'd2, 1'b0, 1'b1, 1'b0, 16'd2, "s_enq2");
    issued(DEQUEUE, 16'd0, 16'd1, 1'b0, 1'b0, 1'b1, 16'd2, "s_deq");
    immediate(PEEK, 16'd0, OK, 16'd1, 0, "s_peek");
    pq_empty = 1'b1;
    immediate(DEQUEUE, 16'd0, REJ_EMPTY, 16'd0, 0, "s_deq_e");
    pq_full  = 1'b1;
    pq_empty = 1'b0;
    immediate(ENQUEUE, 16'd9, REJ_FULL, 16'd9, 0, "s_enq_f");
    pq_full = 1'b0;
`ifdef PQ_CMD_ISSUER_STATS_EN
    chk("stat_issued", stat_issued, 16'd3);
    chk("stat_rejected", stat_rejected, 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
